// File: rtl/ram_responder_if.sv
// Request/response bundle between a memory requester and the RAM responder.
interface ram_responder_if;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport master (
      output ramaddr, ramstore, ramREN, ramWEN,
      input  ramload, ramstate
   );

   modport slave (
      input  ramaddr, ramstore, ramREN, ramWEN,
      output ramload, ramstate
   );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM model with a fixed wait latency. A level-held request
// shows BUSY for LAT cycles, then ACCESS for one cycle. Reads return data
// during ACCESS, and writes commit at the edge that ends ACCESS.
module ram_responder #(
   parameter int LAT   = 2,    // wait cycles before ACCESS, 1..15
   parameter int DEPTH = 256   // words of storage, power of two
) (
   input  logic            CLK,
   input  logic            nRST,
   ram_responder_if.slave  bus
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACC = 2'd2} fsm_t;

   fsm_t        state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        op_q, op_d;          // 1 = write
   logic [31:0] mem_q [DEPTH];

   logic        any_req, in_range, req_ok, match, access, start;
   ramstate_t   rs;
   logic [31:0] load;

   assign any_req  = bus.ramREN | bus.ramWEN;
   assign in_range = (bus.ramaddr >> (AW + 2)) == 32'd0;
   assign req_ok   = (bus.ramREN ^ bus.ramWEN) && (bus.ramaddr[1:0] == 2'b00) && in_range;
   // The request on the pins is the one that is currently latched.
   assign match    = (bus.ramaddr == addr_q) && (bus.ramWEN == op_q);
   assign access   = (state_q == ACC) && req_ok && match;

   // State register, latched request and wait counter.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
      end
   end

   // Next-state logic. Both a fresh request and a changed request start here.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      op_d    = op_q;
      start   = 1'b0;
      case (state_q)
         IDLE: start = req_ok;
         WAIT: begin
            if (!req_ok) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (!match) begin
               start = 1'b1;
            end else if (cnt_q <= 4'd1) begin
               state_d = ACC;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACC: begin
            // A held request re-enters through IDLE, so it sees a full LAT of BUSY.
            if (!req_ok || match) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               start = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      if (start) begin
         addr_d = bus.ramaddr;
         op_d   = bus.ramWEN;
         if (LAT > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
         end else begin
            state_d = ACC;
            cnt_d   = 4'd0;
         end
      end
   end

   // Outputs. The state is never FREE while any request line is high.
   always_comb begin
      rs   = BUSY;
      load = 32'd0;
      if (!any_req)
         rs = FREE;
      else if (!req_ok)
         rs = ERROR;
      else if ((state_q == ACC) && match)
         rs = ACCESS;
      if (access && !op_q)
         load = mem_q[addr_q[AW+1:2]];
   end

   assign bus.ramstate = rs;
   assign bus.ramload  = load;

   // Storage. It is cleared on reset, and a write commits only at the end of its ACCESS cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end else if (access && op_q) begin
         mem_q[addr_q[AW+1:2]] <= bus.ramstore;
      end
   end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The block SHALL have parameter LAT, default 2, giving the wait cycles before ACCESS; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit words of storage; it SHALL be a power of two.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ramaddr, input, 32 bits (word_t): byte address; the word index is ramaddr[log2(DEPTH)+1:2].
REQ-006 The block SHALL have port ramstore, input, 32 bits: write data.
REQ-007 The block SHALL have port ramREN, input, 1 bit: read request, level-held until completion.
REQ-008 The block SHALL have port ramWEN, input, 1 bit: write request, level-held until completion.
REQ-009 The block SHALL have port ramload, output, 32 bits: read data.
REQ-010 The block SHALL have port ramstate, output, 2 bits (ramstate_t), encoded FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-011 The block SHALL treat a request as valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0, and ramaddr < 4*DEPTH.
REQ-012 ramstate SHALL be combinational: FREE if ramREN=ramWEN=0; ERROR if both high, misaligned, or out of range; ACCESS if the FSM is in ACC and the current request matches the latched one; BUSY otherwise.
REQ-013 ramstate SHALL never show FREE while any request is high, because the arbiter reads FREE as "no wait".
REQ-014 The FSM SHALL have the states IDLE, WAIT and ACC; it SHALL hold a latched address, a latched op (read/write) and a 4-bit down-counter.
REQ-015 In IDLE with a valid request, at the edge the block SHALL latch the address and op and go to WAIT with cnt=LAT-1 when LAT>1, or go to ACC when LAT=1.
REQ-016 In WAIT with a matching request, the block SHALL decrement cnt and go to ACC at the edge where cnt==0.
REQ-017 Net latency: a valid request first seen in cycle t0 and held unchanged SHALL show BUSY in cycles t0..t0+LAT-1 and ACCESS in cycle t0+LAT.
REQ-018 A change of address or op in WAIT or ACC SHALL show BUSY that cycle, re-latch the new request, and restart the count exactly as from IDLE.
REQ-019 If the request drops, or becomes invalid, in WAIT or ACC, the block SHALL return to IDLE at the edge, abort the transaction and commit no write.
REQ-020 A write SHALL commit mem[index] <= ramstore at the edge ending the ACCESS cycle; ramstore SHALL be sampled in that cycle.
REQ-021 In the ACCESS cycle of a read, ramload SHALL equal mem[latched index]; in all other cycles ramload SHALL be 32'h0.
REQ-022 After an ACC cycle, a request still held unchanged SHALL be treated as a new transaction: BUSY for LAT cycles, then ACCESS again, with a write committed again.
REQ-023 An invalid request SHALL keep the FSM in, or return it to, IDLE and SHALL never modify memory.

Reset
REQ-024 While nRST=0 (asynchronous), the FSM SHALL be in IDLE, cnt SHALL be 0, the latched address and op SHALL be 0, and every mem word SHALL be 0.
REQ-025 During reset, ramload SHALL be 32'h0 and ramstate SHALL follow REQ-012 with the FSM in IDLE (FREE or BUSY/ERROR by inputs).
REQ-026 Reset asserted mid-transaction SHALL abort it with no write committed; after release, a held request SHALL restart from t0.

Verification (LAT=2, DEPTH=256)
REQ-027 Write 32'hDEADBEEF to 32'h10, held: states BUSY, BUSY, ACCESS; then drop ramWEN -> FREE; mem[4]=32'hDEADBEEF.
REQ-028 Read 32'h10 afterwards: BUSY, BUSY, then ACCESS with ramload=32'hDEADBEEF; ramload=0 in both BUSY cycles.
REQ-029 Read 32'h20, with the address changed to 32'h24 in the 2nd cycle: BUSY for 3 cycles total, then ACCESS returning mem[9].
REQ-030 Write 32'h1234 to 32'h30, with ramWEN dropped after 1 BUSY cycle: ramstate=FREE; a subsequent read of 32'h30 returns 32'h0.
REQ-031 Error cases: ramREN=ramWEN=1 -> ERROR; ramaddr=32'h2 -> ERROR; ramaddr=32'h400 -> ERROR; memory unchanged in all three.
REQ-032 Reset in the ACCESS cycle of a write to 32'h8: the word stays 0; with the request still held after release, the sequence is BUSY, BUSY, ACCESS.
